// File: rtl/tsmp_ftable_ram_arbiter.sv
// Shares one single-port forward-table RAM between the MID lookup engine and the config path.
// Optional conflict statistics counter: define TSMP_FTABLE_ARB_STAT_EN.
module tsmp_ftable_ram_arbiter #(
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lkp_rd,
  input  logic [11:0] iv_lkp_addr,
  output logic        o_lkp_busy,
  output logic        o_lkp_rvalid,
  output logic [33:0] ov_lkp_rdata,
  input  logic        i_cfg_wr,
  input  logic        i_cfg_rd,
  input  logic [11:0] iv_cfg_addr,
  input  logic [33:0] iv_cfg_wdata,
  output logic        o_cfg_busy,
  output logic        o_cfg_rvalid,
  output logic [33:0] ov_cfg_rdata,
  output logic [11:0] ov_ram_addr,
  output logic [33:0] ov_ram_wdata,
  output logic        o_ram_wr,
  output logic        o_ram_rd,
  input  logic [33:0] iv_ram_rdata,
  output logic [15:0] ov_conflict_cnt
);

  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} cfg_op_e;
  typedef enum logic {OWN_LKP = 1'b0, OWN_CFG = 1'b1} owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        r_lkp_pend;
  logic [11:0] r_lkp_addr;
  logic        r_cfg_pend;
  cfg_op_e     r_cfg_op;
  logic [11:0] r_cfg_addr;
  logic [33:0] r_cfg_wdata;
  logic [3:0]  r_starve_cnt;

  logic [11:0] r_ram_addr;
  logic [33:0] r_ram_wdata;
  logic        r_ram_wr;
  logic        r_ram_rd;
  owner_e      r_ram_owner;

  logic [RD_LAT-1:0] r_tag_v;
  owner_e            r_tag_own [RD_LAT];

  logic w_grant_lkp;
  logic w_grant_cfg;
  logic w_lkp_accept;
  logic w_cfg_accept;

  // Lookup wins contention unless config has waited through STARVE_LIMIT lookup grants.
  always_comb begin
    w_grant_cfg = r_cfg_pend & (~r_lkp_pend | (r_starve_cnt == LIMIT));
    w_grant_lkp = r_lkp_pend & ~w_grant_cfg;
  end

  assign o_lkp_busy   = r_lkp_pend & ~w_grant_lkp;
  assign o_cfg_busy   = r_cfg_pend & ~w_grant_cfg;
  assign w_lkp_accept = i_lkp_rd & ~o_lkp_busy;
  assign w_cfg_accept = (i_cfg_wr | i_cfg_rd) & ~o_cfg_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lkp_pend   <= 1'b0;
      r_lkp_addr   <= '0;
      r_cfg_pend   <= 1'b0;
      r_cfg_op     <= OP_RD;
      r_cfg_addr   <= '0;
      r_cfg_wdata  <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_lkp_accept) begin
        r_lkp_pend <= 1'b1;
        r_lkp_addr <= iv_lkp_addr;
      end else if (w_grant_lkp) begin
        r_lkp_pend <= 1'b0;
      end

      if (w_cfg_accept) begin
        r_cfg_pend  <= 1'b1;
        r_cfg_op    <= i_cfg_wr ? OP_WR : OP_RD;
        r_cfg_addr  <= iv_cfg_addr;
        r_cfg_wdata <= iv_cfg_wdata;
      end else if (w_grant_cfg) begin
        r_cfg_pend <= 1'b0;
      end

      if (r_cfg_pend & w_grant_lkp) begin
        if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_rd    <= 1'b0;
      r_ram_owner <= OWN_LKP;
    end else begin
      r_ram_wr <= 1'b0;
      r_ram_rd <= 1'b0;
      if (w_grant_lkp) begin
        r_ram_addr  <= r_lkp_addr;
        r_ram_rd    <= 1'b1;
        r_ram_owner <= OWN_LKP;
      end else if (w_grant_cfg) begin
        r_ram_addr  <= r_cfg_addr;
        r_ram_owner <= OWN_CFG;
        if (r_cfg_op == OP_WR) begin
          r_ram_wdata <= r_cfg_wdata;
          r_ram_wr    <= 1'b1;
        end else begin
          r_ram_rd <= 1'b1;
        end
      end
    end
  end

  // Tag pipeline tracks which requester owns each in-flight RAM read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_v <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) r_tag_own[i] <= OWN_LKP;
    end else begin
      r_tag_v[0]   <= r_ram_rd;
      r_tag_own[0] <= r_ram_owner;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  assign o_lkp_rvalid = r_tag_v[RD_LAT-1] & (r_tag_own[RD_LAT-1] == OWN_LKP);
  assign o_cfg_rvalid = r_tag_v[RD_LAT-1] & (r_tag_own[RD_LAT-1] == OWN_CFG);
  assign ov_lkp_rdata = iv_ram_rdata;
  assign ov_cfg_rdata = iv_ram_rdata;

  assign ov_ram_addr  = r_ram_addr;
  assign ov_ram_wdata = r_ram_wdata;
  assign o_ram_wr     = r_ram_wr;
  assign o_ram_rd     = r_ram_rd;

`ifdef TSMP_FTABLE_ARB_STAT_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_conflict_cnt <= '0;
    end else if (r_lkp_pend & r_cfg_pend & (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign ov_conflict_cnt = r_conflict_cnt;
`else
  assign ov_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_tsmp_ftable_ram_arbiter.sv
// Self-checking bench for tsmp_ftable_ram_arbiter: directed scenarios plus randomized traffic vs. a memory model.
module tb_tsmp_ftable_ram_arbiter;

  localparam int unsigned RD_LAT       = 2;
  localparam int unsigned STARVE_LIMIT = 4;
`ifdef TSMP_FTABLE_ARB_STAT_EN
  localparam logic [15:0] EXP_CONF = 16'd3;
`else
  localparam logic [15:0] EXP_CONF = 16'd0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_lkp_rd;
  logic [11:0] iv_lkp_addr;
  logic        o_lkp_busy;
  logic        o_lkp_rvalid;
  logic [33:0] ov_lkp_rdata;
  logic        i_cfg_wr;
  logic        i_cfg_rd;
  logic [11:0] iv_cfg_addr;
  logic [33:0] iv_cfg_wdata;
  logic        o_cfg_busy;
  logic        o_cfg_rvalid;
  logic [33:0] ov_cfg_rdata;
  logic [11:0] ov_ram_addr;
  logic [33:0] ov_ram_wdata;
  logic        o_ram_wr;
  logic        o_ram_rd;
  logic [33:0] iv_ram_rdata;
  logic [15:0] ov_conflict_cnt;

  int checks = 0;
  int fails  = 0;

  logic [33:0] model_mem [4096];
  logic [33:0] lkp_exp [$];
  logic [33:0] cfg_exp [$];

  tsmp_ftable_ram_arbiter #(.RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_lkp_rd(i_lkp_rd), .iv_lkp_addr(iv_lkp_addr), .o_lkp_busy(o_lkp_busy),
    .o_lkp_rvalid(o_lkp_rvalid), .ov_lkp_rdata(ov_lkp_rdata),
    .i_cfg_wr(i_cfg_wr), .i_cfg_rd(i_cfg_rd), .iv_cfg_addr(iv_cfg_addr),
    .iv_cfg_wdata(iv_cfg_wdata), .o_cfg_busy(o_cfg_busy),
    .o_cfg_rvalid(o_cfg_rvalid), .ov_cfg_rdata(ov_cfg_rdata),
    .ov_ram_addr(ov_ram_addr), .ov_ram_wdata(ov_ram_wdata),
    .o_ram_wr(o_ram_wr), .o_ram_rd(o_ram_rd), .iv_ram_rdata(iv_ram_rdata),
    .ov_conflict_cnt(ov_conflict_cnt)
  );

  always #4 i_clk = ~i_clk;

  function automatic logic [33:0] init_val(input int a);
    logic [21:0] hi;
    hi = 22'(a * 40503 + 7);
    return {hi, 12'(a)};
  endfunction

  // Behavioural single-port RAM with RD_LAT read latency; idle slots return zero.
  logic        ram_ready = 1'b0;
  logic [33:0] ram_mem [4096];
  logic [33:0] rpipe [RD_LAT];

  always @(posedge i_clk) begin
    if (!ram_ready) begin
      for (int a = 0; a < 4096; a++) ram_mem[a] <= init_val(a);
      ram_ready <= 1'b1;
    end else if (o_ram_wr) begin
      ram_mem[ov_ram_addr] <= ov_ram_wdata;
    end
    rpipe[0] <= o_ram_rd ? ram_mem[ov_ram_addr] : '0;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  assign iv_ram_rdata = rpipe[RD_LAT-1];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", checks, fails);
    $fatal(1);
  end

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_lkp_rd = 1'b0; iv_lkp_addr = '0;
    i_cfg_wr = 1'b0; i_cfg_rd = 1'b0; iv_cfg_addr = '0; iv_cfg_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (3) step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    repeat (4) step();
    checks++;
    if ({o_lkp_busy, o_lkp_rvalid, o_cfg_busy, o_cfg_rvalid, o_ram_wr, o_ram_rd} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {o_lkp_busy, o_lkp_rvalid, o_cfg_busy, o_cfg_rvalid, o_ram_wr, o_ram_rd});
    end
    checks++;
    if ({ov_ram_addr, ov_ram_wdata, ov_conflict_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h conf=%h want 0", ov_ram_addr, ov_ram_wdata, ov_conflict_cnt);
    end
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_lookup_read();
    i_lkp_rd = 1'b1; iv_lkp_addr = 12'h005;
    step();
    i_lkp_rd = 1'b0;
    checks++;
    if (o_ram_rd !== 1'b0) begin fails++; $display("FAIL lkp_c1_ram_rd: got %b want 0", o_ram_rd); end
    step();
    checks++;
    if (o_ram_rd !== 1'b1 || ov_ram_addr !== 12'h005 || o_ram_wr !== 1'b0) begin
      fails++; $display("FAIL lkp_c2_ram: rd=%b wr=%b addr=%h want rd=1 wr=0 addr=005", o_ram_rd, o_ram_wr, ov_ram_addr);
    end
    step();
    checks++;
    if (o_lkp_rvalid !== 1'b0) begin fails++; $display("FAIL lkp_c3_rvalid: got %b want 0", o_lkp_rvalid); end
    step();
    checks++;
    if (o_lkp_rvalid !== 1'b1 || ov_lkp_rdata !== model_mem[5] || o_cfg_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL lkp_c4_data: rvalid=%b data=%h cfg_rvalid=%b want 1 %h 0",
               o_lkp_rvalid, ov_lkp_rdata, o_cfg_rvalid, model_mem[5]);
    end
    step();
    checks++;
    if (o_lkp_rvalid !== 1'b0) begin fails++; $display("FAIL lkp_c5_rvalid: got %b want 0", o_lkp_rvalid); end
  endtask

  task automatic test_simultaneous();
    i_lkp_rd = 1'b1; iv_lkp_addr = 12'h010;
    i_cfg_wr = 1'b1; iv_cfg_addr = 12'h020; iv_cfg_wdata = 34'h1_2345_6789;
    model_mem[12'h020] = 34'h1_2345_6789;
    step();
    idle_inputs();
    checks++;
    if (o_cfg_busy !== 1'b1 || o_lkp_busy !== 1'b0) begin
      fails++; $display("FAIL sim_c1_busy: cfg=%b lkp=%b want cfg=1 lkp=0", o_cfg_busy, o_lkp_busy);
    end
    step();
    checks++;
    if (o_ram_rd !== 1'b1 || o_ram_wr !== 1'b0 || ov_ram_addr !== 12'h010 || o_cfg_busy !== 1'b0) begin
      fails++;
      $display("FAIL sim_c2_lkp_first: rd=%b wr=%b addr=%h cfg_busy=%b want 1 0 010 0",
               o_ram_rd, o_ram_wr, ov_ram_addr, o_cfg_busy);
    end
    step();
    checks++;
    if (o_ram_wr !== 1'b1 || o_ram_rd !== 1'b0 || ov_ram_addr !== 12'h020 || ov_ram_wdata !== 34'h1_2345_6789) begin
      fails++;
      $display("FAIL sim_c3_cfg_wr: wr=%b rd=%b addr=%h wdata=%h want 1 0 020 123456789",
               o_ram_wr, o_ram_rd, ov_ram_addr, ov_ram_wdata);
    end
    step();
    checks++;
    if (o_lkp_rvalid !== 1'b1 || ov_lkp_rdata !== model_mem[12'h010]) begin
      fails++; $display("FAIL sim_c4_lkp_data: rvalid=%b data=%h want 1 %h", o_lkp_rvalid, ov_lkp_rdata, model_mem[12'h010]);
    end
    repeat (3) step();
  endtask

  task automatic test_starvation();
    for (int pass = 0; pass < 2; pass++) begin
      int lkp_reads = 0;
      int lbusy = 0;
      int cbusy = 0;
      int cyc = 0;
      bit cfg_seen = 1'b0;
      i_cfg_rd = 1'b1; iv_cfg_addr = 12'hABC;
      i_lkp_rd = 1'b1; iv_lkp_addr = 12'h100 + 12'(pass * 64);
      step();
      i_cfg_rd = 1'b0;
      while (!cfg_seen && cyc < 20) begin
        if (o_ram_rd && ov_ram_addr == 12'hABC) cfg_seen = 1'b1;
        else if (o_ram_rd) lkp_reads++;
        if (o_lkp_busy) lbusy++;
        if (o_cfg_busy) cbusy++;
        if (!o_lkp_busy) iv_lkp_addr = 12'h101 + 12'(pass * 64 + cyc);
        step();
        cyc++;
      end
      i_lkp_rd = 1'b0;
      checks++;
      if (!cfg_seen) begin fails++; $display("FAIL starve_timeout: pass %0d cfg read never issued within 20 cycles", pass); end
      checks++;
      if (lkp_reads != STARVE_LIMIT) begin
        fails++; $display("FAIL starve_grants: pass %0d got %0d lookup reads before config, want %0d", pass, lkp_reads, STARVE_LIMIT);
      end
      checks++;
      if (lbusy != 1) begin fails++; $display("FAIL starve_lkp_busy: pass %0d got %0d busy cycles want 1", pass, lbusy); end
      checks++;
      if (cbusy != STARVE_LIMIT) begin
        fails++; $display("FAIL starve_cfg_busy: pass %0d got %0d busy cycles want %0d", pass, cbusy, STARVE_LIMIT);
      end
      repeat (RD_LAT + 4) step();
    end
  endtask

  task automatic test_write_then_read();
    int cyc;
    i_cfg_wr = 1'b1; iv_cfg_addr = 12'h0FF; iv_cfg_wdata = 34'h2_AAAA_5555;
    model_mem[12'h0FF] = 34'h2_AAAA_5555;
    step();
    i_cfg_wr = 1'b0;
    i_lkp_rd = 1'b1; iv_lkp_addr = 12'h0FF;
    step();
    i_lkp_rd = 1'b0;
    cyc = 2;
    while (!o_lkp_rvalid && cyc < 12) begin step(); cyc++; end
    checks++;
    if (!o_lkp_rvalid) begin fails++; $display("FAIL wr_rd_timeout: lookup rvalid never seen"); end
    checks++;
    if (cyc != 5) begin fails++; $display("FAIL wr_rd_latency: rvalid at cycle %0d want 5", cyc); end
    checks++;
    if (ov_lkp_rdata !== 34'h2_AAAA_5555) begin
      fails++; $display("FAIL wr_rd_data: got %h want 2aaaa5555", ov_lkp_rdata);
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    int bad;
    i_lkp_rd = 1'b1; iv_lkp_addr = 12'h033;
    step();
    i_lkp_rd = 1'b0;
    step();
    checks++;
    if (o_ram_rd !== 1'b1) begin fails++; $display("FAIL rstmid_issue: ram_rd=%b want 1", o_ram_rd); end
    step();
    i_rst_n = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if ({o_lkp_rvalid, o_cfg_rvalid, o_lkp_busy, o_cfg_busy, o_ram_rd, o_ram_wr} !== 6'b0 ||
          {ov_ram_addr, ov_ram_wdata, ov_conflict_cnt} !== '0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL rstmid_outputs: %0d cycles with nonzero outputs, want 0", bad); end
    checks++;
    if (ov_lkp_rdata !== '0 || ov_cfg_rdata !== '0) begin
      fails++; $display("FAIL rstmid_rdata: lkp=%h cfg=%h want 0", ov_lkp_rdata, ov_cfg_rdata);
    end
    i_rst_n = 1'b1;
    step();
    i_lkp_rd = 1'b1; iv_lkp_addr = 12'h044;
    step();
    i_lkp_rd = 1'b0;
    step(); step(); step();
    checks++;
    if (o_lkp_rvalid !== 1'b1 || ov_lkp_rdata !== model_mem[12'h044] || o_cfg_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_after: rvalid=%b data=%h cfg_rvalid=%b want 1 %h 0",
               o_lkp_rvalid, ov_lkp_rdata, o_cfg_rvalid, model_mem[12'h044]);
    end
    repeat (3) step();
  endtask

  task automatic test_stat();
    apply_reset();
    i_lkp_rd = 1'b1; iv_lkp_addr = 12'h300;
    i_cfg_rd = 1'b1; iv_cfg_addr = 12'h900;
    step();
    i_cfg_rd = 1'b0; iv_lkp_addr = 12'h301;
    step();
    iv_lkp_addr = 12'h302;
    step();
    i_lkp_rd = 1'b0;
    repeat (3) step();
    checks++;
    if (ov_conflict_cnt !== EXP_CONF) begin
      fails++; $display("FAIL stat_conflict: got %0d want %0d", ov_conflict_cnt, EXP_CONF);
    end
    repeat (RD_LAT + 3) step();
  endtask

  task automatic test_random();
    int lstreak = 0;
    int cstreak = 0;
    for (int cyc = 0; cyc < 3000 + 24; cyc++) begin
      bit driving;
      driving = (cyc < 3000);
      if (o_lkp_rvalid) begin
        checks++;
        if (lkp_exp.size() == 0) begin
          fails++; $display("FAIL rnd_lkp_unexpected: rvalid with data %h, nothing outstanding", ov_lkp_rdata);
        end else begin
          if (ov_lkp_rdata !== lkp_exp[0]) begin
            fails++; $display("FAIL rnd_lkp_data: got %h want %h", ov_lkp_rdata, lkp_exp[0]);
          end
          void'(lkp_exp.pop_front());
        end
      end
      if (o_cfg_rvalid) begin
        checks++;
        if (cfg_exp.size() == 0) begin
          fails++; $display("FAIL rnd_cfg_unexpected: rvalid with data %h, nothing outstanding", ov_cfg_rdata);
        end else begin
          if (ov_cfg_rdata !== cfg_exp[0]) begin
            fails++; $display("FAIL rnd_cfg_data: got %h want %h", ov_cfg_rdata, cfg_exp[0]);
          end
          void'(cfg_exp.pop_front());
        end
      end
      lstreak = o_lkp_busy ? lstreak + 1 : 0;
      cstreak = o_cfg_busy ? cstreak + 1 : 0;
      if (o_cfg_busy) begin
        checks++;
        if (cstreak > STARVE_LIMIT) begin
          fails++; $display("FAIL rnd_cfg_starved: busy for %0d cycles, limit %0d", cstreak, STARVE_LIMIT);
        end
      end
      if (o_lkp_busy) begin
        checks++;
        if (lstreak > 1) begin fails++; $display("FAIL rnd_lkp_busy_run: busy for %0d cycles, max 1", lstreak); end
      end
      if (o_ram_rd || o_ram_wr) begin
        checks++;
        if (o_ram_rd && o_ram_wr) begin fails++; $display("FAIL rnd_ram_cmd: rd=%b wr=%b both high", o_ram_rd, o_ram_wr); end
      end

      idle_inputs();
      if (driving) begin
        if (!o_lkp_busy) begin
          if ($urandom_range(0, 99) < 70) begin
            i_lkp_rd = 1'b1;
            iv_lkp_addr = 12'($urandom_range(0, 12'h7FF));
            lkp_exp.push_back(model_mem[iv_lkp_addr]);
          end
        end else if ($urandom_range(0, 99) < 50) begin
          // Presented while busy: must be ignored, so nothing is expected from it.
          i_lkp_rd = 1'b1;
          iv_lkp_addr = 12'($urandom_range(0, 4095));
        end
        if (!o_cfg_busy && $urandom_range(0, 99) < 40) begin
          int kind;
          kind = $urandom_range(0, 2);
          iv_cfg_addr  = 12'h800 + 12'($urandom_range(0, 15));
          iv_cfg_wdata = 34'({$urandom(), $urandom()});
          i_cfg_wr = (kind != 1);
          i_cfg_rd = (kind != 0);
          if (i_cfg_wr) model_mem[iv_cfg_addr] = iv_cfg_wdata;
          else cfg_exp.push_back(model_mem[iv_cfg_addr]);
        end
      end
      step();
    end
    checks++;
    if (lkp_exp.size() != 0 || cfg_exp.size() != 0) begin
      fails++; $display("FAIL rnd_drain: %0d lookup and %0d config reads never returned, want 0", lkp_exp.size(), cfg_exp.size());
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) model_mem[a] = init_val(a);
    idle_inputs();
    i_rst_n = 1'b1;
    step();
    test_reset();
    test_lookup_read();
    test_simultaneous();
    test_starvation();
    test_write_then_read();
    test_reset_mid();
    test_stat();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/tsmp_ftable_ram_arbiter.md
Name: tsmp_ftable_ram_arbiter

Overview:
- Shares one single-port 34-bit x 4096 TSMP forward-table RAM between two requesters: the MID lookup engine (read-only, latency-critical) and the configuration command path (read/write, background).
- Registers requests, arbitrates with lookup priority plus a starvation guard for config, drives the RAM port, and steers returned read data to the requester that issued it.
- Sits between mid_lookup_table / command_parse_and_encapsulate_tft and the forward-table RAM, replacing the dual-port RAM.

Parameters:
- RD_LAT, 2, RAM read latency in cycles from o_ram_rd high to iv_ram_rdata valid (1..4).
- STARVE_LIMIT, 4, consecutive lookup grants while config is pending before config is forced (1..15).

Ports:
- i_clk  in  1  125 MHz clock
- i_rst_n  in  1  asynchronous active-low reset
- i_lkp_rd  in  1  lookup read request, one cycle per request
- iv_lkp_addr  in  12  lookup read address
- o_lkp_busy  out  1  lookup request cannot be accepted this cycle
- o_lkp_rvalid  out  1  lookup read data valid
- ov_lkp_rdata  out  34  lookup read data
- i_cfg_wr  in  1  config write request
- i_cfg_rd  in  1  config read request
- iv_cfg_addr  in  12  config address
- iv_cfg_wdata  in  34  config write data
- o_cfg_busy  out  1  config request cannot be accepted this cycle
- o_cfg_rvalid  out  1  config read data valid
- ov_cfg_rdata  out  34  config read data
- ov_ram_addr  out  12  RAM address
- ov_ram_wdata  out  34  RAM write data
- o_ram_wr  out  1  RAM write enable
- o_ram_rd  out  1  RAM read enable
- iv_ram_rdata  in  34  RAM read data
- ov_conflict_cnt  out  16  simultaneous-pending conflict count (optional feature)

Behaviour:
- Clock i_clk. Reset i_rst_n is asynchronous and active-low. All outputs reset to 0. Reset clears the pending registers, the starvation counter, the read-tag pipeline and the stat counter. In-flight reads at reset produce no rvalid.
- One pending register per requester holds address, write data and op. A request is accepted when busy is 0 and the request is high.
- o_x_busy = pend_x & !grant_x (combinational), so a requester whose slot is being granted can present a new request in the same cycle. Sustained throughput is 1 request/cycle when there is no contention.
- Requests presented while busy=1 are ignored. Requesters must hold off while busy is high.
- Config op when both i_cfg_wr and i_cfg_rd are high: write wins and the read is dropped.
- Grant is computed combinationally from the pending registers:
  - Only one pending: grant it.
  - Both pending: grant lookup, unless starve_cnt == STARVE_LIMIT, in which case grant config.
- starve_cnt (4-bit):
  - Increments when config is pending and lookup is granted, saturating at STARVE_LIMIT.
  - Clears when config is granted or config is not pending.
- RAM command is registered. The grant in cycle C drives ov_ram_addr/wdata and o_ram_wr or o_ram_rd during cycle C+1 for exactly one cycle. The pending register clears at the same edge. When nothing is granted, o_ram_wr = o_ram_rd = 0 and addr/wdata hold their last values.
- Read steering: a RD_LAT-deep shift register of {valid, owner} tags is loaded when o_ram_rd issues.
  - When the tag emerges (cycle C+1+RD_LAT), the owner's rvalid is high for one cycle.
  - Both ov_lkp_rdata and ov_cfg_rdata = iv_ram_rdata (combinational pass-through).
- Latency: request in cycle R with no contention → RAM read in R+2 → rvalid in R+2+RD_LAT.
- Ordering: each requester's operations complete in issue order. A config write granted before a lookup read to the same address is visible to that read.

Optional Feature:
- Macro TSMP_FTABLE_ARB_STAT_EN.
- Defined: ov_conflict_cnt increments by 1 each cycle both pending registers are set. It saturates at 16'hFFFF and clears only on reset.
- Undefined: ov_conflict_cnt is tied to 16'h0 and no counter logic is synthesised.

Test Plan:
- Lookup-only read, RD_LAT=2: i_lkp_rd=1 with addr 12'h005 in cycle 0 → o_ram_rd with ov_ram_addr=12'h005 in cycle 2; o_lkp_rvalid with RAM data in cycle 4; o_cfg_rvalid stays 0.
- Simultaneous requests: lookup rd 12'h010 and config wr 12'h020 / 34'h1_2345_6789 in the same cycle → lookup RAM read issues first, config write the next cycle; o_cfg_busy=1 for exactly 1 cycle.
- Starvation, STARVE_LIMIT=4: config rd pending under continuous lookup reads → config granted after exactly 4 lookup grants; lookup busy=1 for that 1 cycle; starve_cnt returns to 0.
- Write-then-read: config write 34'h2_AAAA_5555 to 12'h0FF, then lookup read 12'h0FF → o_lkp_rvalid returns 34'h2_AAAA_5555.
- Reset mid-operation: assert i_rst_n=0 one cycle after o_ram_rd issues → no rvalid on either port; all outputs 0; a normal read after release completes correctly.
- Stat counter with TSMP_FTABLE_ARB_STAT_EN defined: 3 cycles of dual pending → ov_conflict_cnt=3. With the macro undefined, it reads 0.
